// File: rtl/hazard_track_unit.sv
// -----------------------------------------------------------------------------
// hazard_track_unit
//
// Purpose:
//   Tracks the hazard-relevant fields of the ID/EX, EX/MEM and MEM/WB pipeline
//   registers (register numbers, write-enable and load flags). These registered
//   fields feed the EX-stage forwarding unit directly.
//   The unit detects load-use and ecall-operand hazards for the instruction in
//   ID, and produces the PC / IF-ID stall enables. It inserts ID/EX bubbles.
//   It also sequences the pipeline drain after a halting ecall.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   if_id_*               fields of the instruction currently in ID
//   ecall_halt_req        a7 value read in ID equals 10 (WB forwarding included)
//   pc_write, if_id_write front-end update enables (0 = stall / frozen)
//   id_ex_*, ex_mem_*,
//   mem_wb_*              registered pipeline fields for the forwarding unit
//   is_halted             pipeline fully drained after a halting ecall
//   stall_count           number of stall cycles (0 unless the counter is built)
//
// Configuration:
//   HAZARD_STALL_CNT_EN   when defined, builds a saturating 32-bit counter of
//                         RUN-state stall cycles. When undefined, stall_count
//                         is tied to 0 and no counter register exists.
// -----------------------------------------------------------------------------
module hazard_track_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int ECALL_REG    = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_id_valid,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        if_id_use_rs1,
  input  logic        if_id_use_rs2,
  input  logic [4:0]  if_id_rd,
  input  logic        if_id_reg_write,
  input  logic        if_id_mem_read,
  input  logic        if_id_is_ecall,
  input  logic        ecall_halt_req,
  output logic        pc_write,
  output logic        if_id_write,
  output logic [4:0]  id_ex_rs1_num,
  output logic [4:0]  id_ex_rs2_num,
  output logic [4:0]  id_ex_rd,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_reg_write,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_reg_write,
  output logic        is_halted,
  output logic [31:0] stall_count
);

  localparam logic [4:0] ECALL_NUM  = ECALL_REG[4:0];
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [2:0] drain_cnt, drain_cnt_next;
  logic       load_use, ecall_wait, stall_raw, stall, bubble;

  // Hazard detection on the ID instruction. x0 never counts as a producer
  // for load-use. The ecall compare needs no x0 guard because ECALL_NUM is
  // nonzero. A MEM/WB producer of a7 is covered by WB internal forwarding,
  // so only the ID/EX and EX/MEM stages can hold a pending a7 write.
  always_comb begin
    load_use = if_id_valid & id_ex_mem_read & id_ex_reg_write & (id_ex_rd != 5'd0) &
               ((if_id_use_rs1 & (if_id_rs1 == id_ex_rd)) |
                (if_id_use_rs2 & (if_id_rs2 == id_ex_rd)));
    ecall_wait = if_id_valid & if_id_is_ecall &
                 ((id_ex_reg_write & (id_ex_rd == ECALL_NUM)) |
                  (ex_mem_reg_write & (ex_mem_rd == ECALL_NUM)));
    stall_raw = load_use | ecall_wait;
    stall     = (state == RUN) & stall_raw;
  end

  // Next-state and front-end control. Outside RUN the front end is frozen
  // and ID/EX is fed bubbles so in-flight instructions drain out.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    pc_write       = 1'b0;
    if_id_write    = 1'b0;
    bubble         = 1'b1;
    case (state)
      RUN: begin
        pc_write    = ~stall;
        if_id_write = ~stall;
        bubble      = stall | ~if_id_valid;
        if (if_id_valid & if_id_is_ecall & ~stall & ecall_halt_req) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_cnt == 3'd0) begin
          state_next = HALTED;
        end else begin
          drain_cnt_next = drain_cnt - 3'd1;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign is_halted = (state == HALTED);

  // State register and the three pipeline field stages. The stages shift
  // on every edge; a bubble zeroes every ID/EX field so it can never look
  // like a producer downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      drain_cnt        <= 3'd0;
      id_ex_rs1_num    <= 5'd0;
      id_ex_rs2_num    <= 5'd0;
      id_ex_rd         <= 5'd0;
      id_ex_reg_write  <= 1'b0;
      id_ex_mem_read   <= 1'b0;
      ex_mem_rd        <= 5'd0;
      ex_mem_reg_write <= 1'b0;
      mem_wb_rd        <= 5'd0;
      mem_wb_reg_write <= 1'b0;
    end else begin
      state            <= state_next;
      drain_cnt        <= drain_cnt_next;
      mem_wb_rd        <= ex_mem_rd;
      mem_wb_reg_write <= ex_mem_reg_write;
      ex_mem_rd        <= id_ex_rd;
      ex_mem_reg_write <= id_ex_reg_write;
      if (bubble) begin
        id_ex_rs1_num   <= 5'd0;
        id_ex_rs2_num   <= 5'd0;
        id_ex_rd        <= 5'd0;
        id_ex_reg_write <= 1'b0;
        id_ex_mem_read  <= 1'b0;
      end else begin
        id_ex_rs1_num   <= if_id_rs1;
        id_ex_rs2_num   <= if_id_rs2;
        id_ex_rd        <= if_id_rd;
        id_ex_reg_write <= if_id_reg_write;
        id_ex_mem_read  <= if_id_mem_read;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles lost to stalls in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_track_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_track_unit
//
// Directed vectors drive the ID-stage inputs one cycle at a time. Each vector
// carries hand-computed expected outputs for that cycle, which go into a
// queue. A separate monitor pops one entry per cycle at the falling edge and
// compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_hazard_track_unit;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_id_valid, if_id_use_rs1, if_id_use_rs2;
  logic        if_id_reg_write, if_id_mem_read, if_id_is_ecall, ecall_halt_req;
  logic [4:0]  if_id_rs1, if_id_rs2, if_id_rd;
  logic        pc_write, if_id_write;
  logic [4:0]  id_ex_rs1_num, id_ex_rs2_num, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic        id_ex_reg_write, id_ex_mem_read, ex_mem_reg_write, mem_wb_reg_write;
  logic        is_halted;
  logic [31:0] stall_count;

  typedef struct {
    logic        pcw;
    logic [4:0]  idrs1;
    logic [4:0]  idrd;
    logic        idmr;
    logic        idrw;
    logic [4:0]  exrd;
    logic        exrw;
    logic [4:0]  wbrd;
    logic        halt;
    logic [31:0] cnt;
    int          step;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  hazard_track_unit dut (
    .clk(clk), .reset(reset),
    .if_id_valid(if_id_valid), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .if_id_rd(if_id_rd), .if_id_reg_write(if_id_reg_write),
    .if_id_mem_read(if_id_mem_read), .if_id_is_ecall(if_id_is_ecall),
    .ecall_halt_req(ecall_halt_req),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_rs1_num(id_ex_rs1_num), .id_ex_rs2_num(id_ex_rs2_num), .id_ex_rd(id_ex_rd),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .is_halted(is_halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // One comparison: bumps the check count and reports any difference.
  task automatic checkOutput(input string name, input int step, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL step %0d %s actual=%0h expected=%0h", step, name, act, exp);
    end
  endtask

  // Drives one cycle of ID inputs just after the rising edge and queues what
  // the DUT outputs should show during that cycle.
  task automatic applyStimulus(
    input logic rst, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
    input logic mr, input logic ec, input logic hr,
    input logic e_pcw, input logic [4:0] e_idrs1, input logic [4:0] e_idrd,
    input logic e_idmr, input logic e_idrw, input logic [4:0] e_exrd,
    input logic e_exrw, input logic [4:0] e_wbrd, input logic e_halt, input int e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; if_id_valid = v; if_id_rs1 = rs1; if_id_rs2 = rs2;
    if_id_use_rs1 = u1; if_id_use_rs2 = u2; if_id_rd = rd;
    if_id_reg_write = rw; if_id_mem_read = mr; if_id_is_ecall = ec;
    ecall_halt_req = hr;
    e.pcw = e_pcw; e.idrs1 = e_idrs1; e.idrd = e_idrd; e.idmr = e_idmr;
    e.idrw = e_idrw; e.exrd = e_exrd; e.exrw = e_exrw; e.wbrd = e_wbrd;
    e.halt = e_halt; e.cnt = CNT_EN ? 32'(e_cnt) : 32'd0; e.step = step_no;
    exp_q.push_back(e);
    step_no++;
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checkOutput("pc_write", cur.step, 32'(pc_write), 32'(cur.pcw));
      checkOutput("if_id_write", cur.step, 32'(if_id_write), 32'(cur.pcw));
      checkOutput("id_ex_rs1_num", cur.step, 32'(id_ex_rs1_num), 32'(cur.idrs1));
      checkOutput("id_ex_rd", cur.step, 32'(id_ex_rd), 32'(cur.idrd));
      checkOutput("id_ex_mem_read", cur.step, 32'(id_ex_mem_read), 32'(cur.idmr));
      checkOutput("id_ex_reg_write", cur.step, 32'(id_ex_reg_write), 32'(cur.idrw));
      checkOutput("ex_mem_rd", cur.step, 32'(ex_mem_rd), 32'(cur.exrd));
      checkOutput("ex_mem_reg_write", cur.step, 32'(ex_mem_reg_write), 32'(cur.exrw));
      checkOutput("mem_wb_rd", cur.step, 32'(mem_wb_rd), 32'(cur.wbrd));
      checkOutput("is_halted", cur.step, 32'(is_halted), 32'(cur.halt));
      checkOutput("stall_count", cur.step, stall_count, cur.cnt);
    end
  end

  // Directed sequence. Columns: reset, valid, rs1, rs2, use1, use2, rd, rw,
  // mr, ecall, halt_req | pc_write, id_ex_rs1, id_ex_rd, id_ex_mr, id_ex_rw,
  // ex_mem_rd, ex_mem_rw, mem_wb_rd, is_halted, stall_count.
  initial begin
    reset = 1'b1; if_id_valid = 1'b0; if_id_rs1 = '0; if_id_rs2 = '0;
    if_id_use_rs1 = 1'b0; if_id_use_rs2 = 1'b0; if_id_rd = '0;
    if_id_reg_write = 1'b0; if_id_mem_read = 1'b0; if_id_is_ecall = 1'b0;
    ecall_halt_req = 1'b0;
    repeat (2) @(posedge clk);
    // reset state
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  1, 0, 0,0,0,  0,0, 0, 0, 0);
    // load-use: lw x5 then add x6,x5,x7
    applyStimulus(0,1, 1,0,1,0, 5,1,1,0,0,  1, 0, 0,0,0,  0,0, 0, 0, 0);
    applyStimulus(0,1, 5,7,1,1, 6,1,0,0,0,  0, 1, 5,1,1,  0,0, 0, 0, 0);
    applyStimulus(0,1, 5,7,1,1, 6,1,0,0,0,  1, 0, 0,0,0,  5,1, 0, 0, 1);
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  1, 5, 6,0,1,  0,0, 5, 0, 1);
    // no false hazard: lw x0 then reader of x0; lw x5 then non-reader
    applyStimulus(0,1, 0,0,1,0, 0,1,1,0,0,  1, 0, 0,0,0,  6,1, 0, 0, 1);
    applyStimulus(0,1, 0,0,1,1, 8,1,0,0,0,  1, 0, 0,1,1,  0,0, 6, 0, 1);
    applyStimulus(0,1, 2,0,1,0, 5,1,1,0,0,  1, 0, 8,0,1,  0,1, 0, 0, 1);
    applyStimulus(0,1, 5,5,0,0, 9,1,0,0,0,  1, 2, 5,1,1,  8,1, 0, 0, 1);
    // ecall wait: addi x17 then non-halting ecall
    applyStimulus(0,1, 0,0,1,0,17,1,0,0,0,  1, 5, 9,0,1,  5,1, 8, 0, 1);
    applyStimulus(0,1,17,0,1,0, 0,0,0,1,0,  0, 0,17,0,1,  9,1, 5, 0, 1);
    applyStimulus(0,1,17,0,1,0, 0,0,0,1,0,  0, 0, 0,0,0, 17,1, 9, 0, 2);
    applyStimulus(0,1,17,0,1,0, 0,0,0,1,0,  1, 0, 0,0,0,  0,0,17, 0, 3);
    // halting ecall, drain 3 cycles, then halted
    applyStimulus(0,1,17,0,1,0, 0,0,0,1,1,  1,17, 0,0,0,  0,0, 0, 0, 3);
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  0,17, 0,0,0,  0,0, 0, 0, 3);
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  0, 0, 0,0,0,  0,0, 0, 0, 3);
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  0, 0, 0,0,0,  0,0, 0, 0, 3);
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  0, 0, 0,0,0,  0,0, 0, 1, 3);
    applyStimulus(1,1, 1,0,1,0, 5,1,1,0,0,  0, 0, 0,0,0,  0,0, 0, 1, 3);
    // reset out of HALTED
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  1, 0, 0,0,0,  0,0, 0, 0, 0);
    // second halt, reset on the second DRAIN cycle
    applyStimulus(0,1,17,0,1,0, 0,0,0,1,1,  1, 0, 0,0,0,  0,0, 0, 0, 0);
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  0,17, 0,0,0,  0,0, 0, 0, 0);
    applyStimulus(1,0, 0,0,0,0, 0,0,0,0,0,  0, 0, 0,0,0,  0,0, 0, 0, 0);
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  1, 0, 0,0,0,  0,0, 0, 0, 0);
    applyStimulus(0,1, 2,0,1,0, 5,1,1,0,0,  1, 0, 0,0,0,  0,0, 0, 0, 0);
    applyStimulus(0,0, 0,0,0,0, 0,0,0,0,0,  1, 2, 5,1,1,  0,0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_queue actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
